// File: rtl/key_sched_pkg.sv
// Shared definitions for the key event scheduler: arbiter state encoding
// and the round-robin index step used by the grant search.
package key_sched_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } arbState_t;

  // Next index after idx in a ring of n entries; n-1 wraps to 0 even when
  // n is not a power of two.
  function automatic int unsigned rrNext(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/key_debounce_filter.sv
// Per-button filter: 2-flop synchroniser on the active-low pin followed by
// a consecutive-mismatch counter. The filtered level flips once the
// synchronised level has disagreed with it for COUNT_NUM cycles in a row.
// oRise is high for exactly the first cycle the filtered level reads 1.
module key_debounce_filter #(
  parameter int COUNT_NUM = 5
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iBtn_n,
  output logic oLevel,
  output logic oRise
);

  localparam int CNT_W = (COUNT_NUM > 1) ? $clog2(COUNT_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COUNT_NUM - 1);

  logic             syncP0;
  logic             syncP1;
  logic [CNT_W-1:0] cnt;

  // Bring the raw pressed level into the iClk domain.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      syncP0 <= 1'b0;
      syncP1 <= 1'b0;
    end else begin
      syncP0 <= ~iBtn_n;
      syncP1 <= syncP0;
    end
  end

  // Count consecutive disagreements; any agreement restarts the count.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt    <= '0;
      oLevel <= 1'b0;
      oRise  <= 1'b0;
    end else begin
      oRise <= 1'b0;
      if (syncP1 == oLevel) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt    <= '0;
        oLevel <= ~oLevel;
        oRise  <= ~oLevel;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_event_scheduler.sv
// Debounces NUM_KEYS active-low buttons, turns each press into a pending
// event and hands events one at a time to the consumer over valid/ready,
// granting in round-robin order starting after the last granted key.
// Optional build macro: KEY_AUTO_REPEAT_EN adds per-key hold timers that
// re-raise an event after REPEAT_DELAY cycles and then every REPEAT_PERIOD.
module key_event_scheduler
  import key_sched_pkg::*;
#(
  parameter int NUM_KEYS      = 4,
  parameter int COUNT_NUM     = 5,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  localparam int KEY_W        = $clog2(NUM_KEYS)
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic [NUM_KEYS-1:0] iBtn_n,
  input  logic                iReady,
  output logic                oValid,
  output logic [KEY_W-1:0]    oKey,
  output logic [NUM_KEYS-1:0] oLevel,
  output logic [NUM_KEYS-1:0] oPending,
  output logic                oDrop
);

  if (NUM_KEYS < 2 || NUM_KEYS > 16 || COUNT_NUM < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gParamCheck
    $error("key_event_scheduler: parameter out of range");
  end

  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] setMask;
  logic [NUM_KEYS-1:0] clrMask;
  logic [NUM_KEYS-1:0] pending;
  logic [KEY_W-1:0]    last;
  logic [KEY_W-1:0]    sel;
  logic                found;
  logic                grant;
  int unsigned         idx;
  arbState_t           state;
  arbState_t           stateNext;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : gKey
    key_debounce_filter #(
      .COUNT_NUM (COUNT_NUM)
    ) uFilter (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iBtn_n (iBtn_n[k]),
      .oLevel (level[k]),
      .oRise  (rise[k])
    );
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [NUM_KEYS-1:0] repFire;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : gRepeat
    logic [HOLD_W-1:0] holdCnt;
    logic [HOLD_W-1:0] target;
    logic              repeating;

    // First repeat waits the long delay, later ones the shorter period.
    assign target     = repeating ? HOLD_W'(REPEAT_PERIOD) : HOLD_W'(REPEAT_DELAY);
    assign repFire[k] = level[k] && (holdCnt == target);

    // Hold timer: counts cycles held, restarts after each repeat fires.
    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
        holdCnt   <= '0;
        repeating <= 1'b0;
      end else if (!level[k]) begin
        holdCnt   <= '0;
        repeating <= 1'b0;
      end else if (repFire[k]) begin
        holdCnt   <= HOLD_W'(1);
        repeating <= 1'b1;
      end else begin
        holdCnt <= holdCnt + 1'b1;
      end
    end
  end

  assign setMask = rise | repFire;
`else
  assign setMask = rise;
`endif

  assign clrMask  = grant ? (NUM_KEYS'(1) << sel) : '0;
  assign oValid   = (state == PRESENT);
  assign oLevel   = level;
  assign oPending = pending;

  // Arbiter state register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Round-robin search from last+1 and grant/handshake transitions.
  always_comb begin
    stateNext = state;
    grant     = 1'b0;
    sel       = '0;
    found     = 1'b0;
    idx       = 32'(last);
    for (int i = 0; i < NUM_KEYS; i++) begin
      idx = rrNext(idx, NUM_KEYS);
      if (!found && pending[KEY_W'(idx)]) begin
        found = 1'b1;
        sel   = KEY_W'(idx);
      end
    end
    case (state)
      IDLE: begin
        if (found) begin
          stateNext = PRESENT;
          grant     = 1'b1;
        end
      end
      PRESENT: begin
        if (iReady) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Pending set/clear (a new set beats a same-cycle grant), drop flag,
  // and the presented key / round-robin pointer captured on grant.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pending <= '0;
      oDrop   <= 1'b0;
      oKey    <= '0;
      last    <= KEY_W'(NUM_KEYS - 1);
    end else begin
      pending <= (pending & ~clrMask) | setMask;
      oDrop   <= |(setMask & pending & ~clrMask);
      if (grant) begin
        oKey <= sel;
        last <= sel;
      end
    end
  end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler with NUM_KEYS=4, COUNT_NUM=5.
module tb_key_event_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_n = 4'hF;
  logic       ready = 1'b0;
  logic       oValid;
  logic [1:0] oKey;
  logic [3:0] oLevel;
  logic [3:0] oPending;
  logic       oDrop;

  int tests = 0;
  int fails = 0;
  int dropCnt = 0;

  always #5 clk = ~clk;

  key_event_scheduler #(
    .NUM_KEYS  (4),
    .COUNT_NUM (5)
  ) dut (
    .iClk     (clk),
    .iRst_n   (rst_n),
    .iBtn_n   (btn_n),
    .iReady   (ready),
    .oValid   (oValid),
    .oKey     (oKey),
    .oLevel   (oLevel),
    .oPending (oPending),
    .oDrop    (oDrop)
  );

  always @(negedge clk) if (oDrop === 1'b1) dropCnt++;

  task automatic pressKey0();
    btn_n = 4'b1110;
    repeat (10) @(negedge clk);
    btn_n = 4'b1111;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_n = 4'b1110; ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (oValid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", oValid); end
    tests++; if (oKey !== 2'd0) begin fails++; $display("FAIL reset_key got %0d want 0", oKey); end
    tests++; if (oLevel !== 4'b0) begin fails++; $display("FAIL reset_level got %b want 0000", oLevel); end
    tests++; if (oPending !== 4'b0) begin fails++; $display("FAIL reset_pending got %b want 0000", oPending); end
    tests++; if (oDrop !== 1'b0) begin fails++; $display("FAIL reset_drop got %b want 0", oDrop); end
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      tests++;
      if (oLevel[0] !== (k == 7)) begin
        fails++; $display("FAIL debounce_latency edge %0d got %b want %b", k, oLevel[0], (k == 7));
      end
    end
    @(negedge clk);
    tests++; if (oValid !== 1'b0 || oPending !== 4'b0001) begin
      fails++; $display("FAIL pending_set got valid=%b pend=%b want valid=0 pend=0001", oValid, oPending);
    end
    @(negedge clk);
    tests++; if (oValid !== 1'b1 || oKey !== 2'd0) begin
      fails++; $display("FAIL first_grant got valid=%b key=%0d want valid=1 key=0", oValid, oKey);
    end
    tests++; if (oPending !== 4'b0) begin fails++; $display("FAIL grant_clears got %b want 0000", oPending); end
    repeat (3) @(negedge clk);
    tests++; if (oValid !== 1'b1 || oKey !== 2'd0) begin
      fails++; $display("FAIL hold_no_ready got valid=%b key=%0d want valid=1 key=0", oValid, oKey);
    end
    ready = 1'b1;
    @(negedge clk);
    tests++; if (oValid !== 1'b0) begin fails++; $display("FAIL handshake_done got %b want 0", oValid); end
    ready = 1'b0; btn_n = 4'hF;
    repeat (12) @(negedge clk);
    tests++; if (oLevel !== 4'b0 || oValid !== 1'b0 || oPending !== 4'b0) begin
      fails++; $display("FAIL release_no_event got lvl=%b valid=%b pend=%b want 0000/0/0000", oLevel, oValid, oPending);
    end
  endtask

  task automatic test_bounce();
    ready = 1'b1; btn_n = 4'b1011;
    repeat (4) @(negedge clk);
    btn_n = 4'hF;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tests++;
      if (oLevel !== 4'b0 || oPending !== 4'b0 || oValid !== 1'b0) begin
        fails++; $display("FAIL bounce cyc %0d got lvl=%b pend=%b valid=%b want all 0", i, oLevel, oPending, oValid);
      end
    end
  endtask

  task automatic test_round_robin();
    int nEv;
    int evKey [2];
    int evCyc [2];
    nEv = 0; evKey[0] = -1; evKey[1] = -1; evCyc[0] = 0; evCyc[1] = 0;
    ready = 1'b1; btn_n = 4'b0101;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (oValid === 1'b1) begin
        if (nEv < 2) begin evKey[nEv] = int'(oKey); evCyc[nEv] = i; end
        if (nEv == 0) begin
          tests++; if (oPending !== 4'b1000) begin
            fails++; $display("FAIL rr_pending got %b want 1000", oPending);
          end
        end
        nEv++;
      end
    end
    tests++; if (nEv != 2) begin fails++; $display("FAIL rr_valid_cycles got %0d want 2", nEv); end
    tests++; if (evKey[0] != 1) begin fails++; $display("FAIL rr_first_key got %0d want 1", evKey[0]); end
    tests++; if (evKey[1] != 3) begin fails++; $display("FAIL rr_second_key got %0d want 3", evKey[1]); end
    tests++; if (evCyc[1] - evCyc[0] != 2) begin
      fails++; $display("FAIL rr_spacing got %0d want 2", evCyc[1] - evCyc[0]);
    end
    btn_n = 4'hF;
    repeat (12) @(negedge clk);
    tests++; if (oValid !== 1'b0 || oPending !== 4'b0) begin
      fails++; $display("FAIL rr_quiet got valid=%b pend=%b want 0/0000", oValid, oPending);
    end
  endtask

  task automatic test_stall_drop();
    int d0;
    ready = 1'b0; d0 = dropCnt;
    pressKey0();
    tests++; if (oValid !== 1'b1 || oKey !== 2'd0 || oPending !== 4'b0) begin
      fails++; $display("FAIL stall_first got valid=%b key=%0d pend=%b want 1/0/0000", oValid, oKey, oPending);
    end
    pressKey0();
    tests++; if (oPending !== 4'b0001 || dropCnt - d0 != 0) begin
      fails++; $display("FAIL stall_second got pend=%b drops=%0d want 0001/0", oPending, dropCnt - d0);
    end
    tests++; if (oValid !== 1'b1 || oKey !== 2'd0) begin
      fails++; $display("FAIL stall_key_stable got valid=%b key=%0d want 1/0", oValid, oKey);
    end
    pressKey0();
    tests++; if (dropCnt - d0 != 1) begin fails++; $display("FAIL drop_count got %0d want 1", dropCnt - d0); end
    tests++; if (oPending !== 4'b0001 || oValid !== 1'b1 || oKey !== 2'd0) begin
      fails++; $display("FAIL drop_state got pend=%b valid=%b key=%0d want 0001/1/0", oPending, oValid, oKey);
    end
    ready = 1'b1;
    @(negedge clk);
    tests++; if (oValid !== 1'b0) begin fails++; $display("FAIL stall_release got %b want 0", oValid); end
    @(negedge clk);
    tests++; if (oValid !== 1'b1 || oKey !== 2'd0 || oPending !== 4'b0) begin
      fails++; $display("FAIL regrant got valid=%b key=%0d pend=%b want 1/0/0000", oValid, oKey, oPending);
    end
    @(negedge clk);
    tests++; if (oValid !== 1'b0) begin fails++; $display("FAIL regrant_done got %b want 0", oValid); end
    ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic seen;
    ready = 1'b0; btn_n = 4'b1110;
    repeat (10) @(negedge clk);
    btn_n = 4'b0100;
    repeat (10) @(negedge clk);
    tests++; if (oValid !== 1'b1 || oKey !== 2'd0 || oPending !== 4'b1010) begin
      fails++; $display("FAIL pre_reset got valid=%b key=%0d pend=%b want 1/0/1010", oValid, oKey, oPending);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (oValid !== 1'b0 || oKey !== 2'd0 || oLevel !== 4'b0 || oPending !== 4'b0 || oDrop !== 1'b0) begin
      fails++; $display("FAIL async_reset got valid=%b key=%0d lvl=%b pend=%b drop=%b want all 0",
                        oValid, oKey, oLevel, oPending, oDrop);
    end
    btn_n = 4'hF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; ready = 1'b1; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (oValid === 1'b1) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0 || oPending !== 4'b0 || oLevel !== 4'b0) begin
      fails++; $display("FAIL post_reset_quiet got seen=%b pend=%b lvl=%b want 0/0000/0000", seen, oPending, oLevel);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bounce();
    test_round_robin();
    test_stall_drop();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
